snake_game_ctrl: RTL and testbench

Per-tick game sequencer for the snake datapath. It initialises the body FIFO and a 256-entry occupancy map, then on each update tick checks the new head position for self-collision and food. It sequences the tail pop and head push on the body FIFO, raises food requests and scores. It gates the move unit (lock) and reports game state to the top level.

---
 rtl/snake_game_ctrl_if.sv | 35 +++
 rtl/snake_game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - signal bundle between the snake sequencer and its datapath
interface snake_game_ctrl_if;
  logic       start;
  logic       tick;
  logic [7:0] head_pos;
  logic [7:0] food_pos;
  logic       food_req;
  logic       food_ack;
  logic [7:0] occ_addr;
  logic       occ_we;
  logic       occ_wd;
  logic       occ_rd;
  logic       fifo_wrreq;
  logic [7:0] fifo_data;
  logic       fifo_rdreq;
  logic [7:0] fifo_q;
  logic       fifo_sclr;
  logic       lock;
  logic       game_over;
  logic       win;
  logic [7:0] score;
  logic [7:0] length;

  modport master (
    input  start, tick, head_pos, food_pos, food_ack, occ_rd, fifo_q,
    output food_req, occ_addr, occ_we, occ_wd, fifo_wrreq, fifo_data,
           fifo_rdreq, fifo_sclr, lock, game_over, win, score, length
  );

  modport slave (
    output start, tick, head_pos, food_pos, food_ack, occ_rd, fifo_q,
    input  food_req, occ_addr, occ_we, occ_wd, fifo_wrreq, fifo_data,
           fifo_rdreq, fifo_sclr, lock, game_over, win, score, length
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - per-tick snake game sequencer (occupancy map, body FIFO, food, score)
module snake_game_ctrl #(
  parameter int         INIT_LEN  = 3,
  parameter int         MAX_LEN   = 128,
  parameter logic [7:0] START_POS = 8'h74
) (
  input logic               clk,
  input logic               reset,
  snake_game_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, SEED, WAIT, READ, CHECK, POP, PUSH, FOOD, OVER
  } state_t;

  state_t     state;
  logic       start_q;
  logic [7:0] h;
  logic       grow;
  logic [3:0] cnt;

  // Seed segment i; the last one lands on START_POS, earlier ones trail toward lower x.
  function automatic logic [7:0] seed_pos(input logic [3:0] i);
    logic [3:0] off;
    off = 4'(INIT_LEN - 1) - i;
    return {START_POS[7:4] - off, START_POS[3:0]};
  endfunction

  logic start_edge, h_food, hit;
  assign start_edge = bus.start & ~start_q;
  assign h_food     = (h == bus.food_pos);
  assign hit        = bus.occ_rd & ~((h == bus.fifo_q) & ~h_food);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      h              <= 8'h00;
      grow           <= 1'b0;
      cnt            <= 4'd0;
      bus.food_req   <= 1'b0;
      bus.occ_addr   <= 8'h00;
      bus.occ_we     <= 1'b0;
      bus.occ_wd     <= 1'b0;
      bus.fifo_wrreq <= 1'b0;
      bus.fifo_data  <= 8'h00;
      bus.fifo_rdreq <= 1'b0;
      bus.fifo_sclr  <= 1'b0;
      bus.lock       <= 1'b1;
      bus.game_over  <= 1'b0;
      bus.win        <= 1'b0;
      bus.score      <= 8'h00;
      bus.length     <= 8'h00;
    end else begin
      start_q        <= bus.start;
      bus.food_req   <= 1'b0;
      bus.occ_we     <= 1'b0;
      bus.occ_wd     <= 1'b0;
      bus.fifo_wrreq <= 1'b0;
      bus.fifo_rdreq <= 1'b0;
      bus.fifo_sclr  <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_edge) begin
            state         <= CLEAR;
            bus.fifo_sclr <= 1'b1;
            bus.occ_addr  <= 8'h00;
            bus.occ_we    <= 1'b1;
            bus.score     <= 8'h00;
            bus.length    <= 8'h00;
            bus.game_over <= 1'b0;
            bus.win       <= 1'b0;
          end
        end
        CLEAR: begin
          if (bus.occ_addr == 8'hff) begin
            state          <= SEED;
            bus.occ_addr   <= seed_pos(4'd0);
            bus.fifo_data  <= seed_pos(4'd0);
            bus.occ_we     <= 1'b1;
            bus.occ_wd     <= 1'b1;
            bus.fifo_wrreq <= 1'b1;
            bus.length     <= bus.length + 8'd1;
            cnt            <= 4'd1;
          end else begin
            bus.occ_addr <= bus.occ_addr + 8'd1;
            bus.occ_we   <= 1'b1;
          end
        end
        SEED: begin
          if (cnt == 4'(INIT_LEN)) begin
            state    <= WAIT;
            bus.lock <= 1'b0;
          end else begin
            bus.occ_addr   <= seed_pos(cnt);
            bus.fifo_data  <= seed_pos(cnt);
            bus.occ_we     <= 1'b1;
            bus.occ_wd     <= 1'b1;
            bus.fifo_wrreq <= 1'b1;
            bus.length     <= bus.length + 8'd1;
            cnt            <= cnt + 4'd1;
          end
        end
        WAIT: begin
          if (bus.tick) begin
            state        <= READ;
            h            <= bus.head_pos;
            bus.occ_addr <= bus.head_pos;
            bus.lock     <= 1'b1;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          grow <= h_food;
          if (hit) begin
            state         <= OVER;
            bus.game_over <= 1'b1;
          end else if (h_food) begin
            state          <= PUSH;
            bus.fifo_wrreq <= 1'b1;
            bus.fifo_data  <= h;
            bus.occ_addr   <= h;
            bus.occ_we     <= 1'b1;
            bus.occ_wd     <= 1'b1;
            bus.length     <= bus.length + 8'd1;
            if (bus.score != 8'hff) bus.score <= bus.score + 8'd1;
          end else begin
            state          <= POP;
            bus.fifo_rdreq <= 1'b1;
            bus.occ_addr   <= bus.fifo_q;
            bus.occ_we     <= 1'b1;
            bus.length     <= bus.length - 8'd1;
          end
        end
        POP: begin
          state          <= PUSH;
          bus.fifo_wrreq <= 1'b1;
          bus.fifo_data  <= h;
          bus.occ_addr   <= h;
          bus.occ_we     <= 1'b1;
          bus.occ_wd     <= 1'b1;
          bus.length     <= bus.length + 8'd1;
        end
        PUSH: begin
          // length already reflects this push, so the win test reads it directly.
          if (grow && bus.length == 8'(MAX_LEN)) begin
            state   <= OVER;
            bus.win <= 1'b1;
          end else if (grow) begin
            state        <= FOOD;
            bus.food_req <= 1'b1;
          end else begin
            state    <= WAIT;
            bus.lock <= 1'b0;
          end
        end
        FOOD: begin
          if (bus.food_ack) begin
            state    <= WAIT;
            bus.lock <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  snake_game_ctrl_if sg();

  snake_game_ctrl #(.INIT_LEN(3), .MAX_LEN(5), .START_POS(8'h74)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sg.master)
  );

  always #5 clk = ~clk;

  // Environment: body FIFO (show-ahead) and 256x1 occupancy RAM with registered read.
  logic [7:0] fifo_body[$];
  logic [7:0] push_log[$];
  logic [7:0] pop_log[$];
  logic       occ_mem[256];
  logic       occ_rd_r = 1'b0;
  logic [7:0] tail_r = 8'h00;
  int         clr_writes = 0;
  int         set_writes = 0;
  int         food_reqs = 0;

  assign sg.occ_rd = occ_rd_r;
  assign sg.fifo_q = tail_r;

  always @(posedge clk) begin
    occ_rd_r <= occ_mem[sg.occ_addr];
    if (sg.occ_we) begin
      occ_mem[sg.occ_addr] = sg.occ_wd;
      if (sg.occ_wd) set_writes++;
      else clr_writes++;
    end
    if (sg.fifo_sclr) fifo_body.delete();
    if (sg.fifo_rdreq && fifo_body.size() > 0) begin
      pop_log.push_back(fifo_body[0]);
      void'(fifo_body.pop_front());
    end
    if (sg.fifo_wrreq) begin
      fifo_body.push_back(sg.fifo_data);
      push_log.push_back(sg.fifo_data);
    end
    if (sg.food_req) food_reqs++;
    tail_r <= (fifo_body.size() > 0) ? fifo_body[0] : 8'h00;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_lock_low(input int limit, output int n);
    n = 0;
    while (sg.lock !== 1'b0 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_tick(input logic [7:0] hp);
    sg.head_pos = hp;
    sg.tick = 1'b1;
    step();
    sg.tick = 1'b0;
  endtask

  task automatic start_game();
    sg.start = 1'b1;
    step();
    sg.start = 1'b0;
  endtask

  int n, p0, q0, f0, lowcnt;

  initial begin
    reset = 1'b0;
    sg.start = 1'b0; sg.tick = 1'b0; sg.head_pos = 8'h00;
    sg.food_pos = 8'h00; sg.food_ack = 1'b0;
    repeat (3) step();
    check("rst_lock", sg.lock, 1);
    check("rst_strobes", {sg.food_req, sg.occ_we, sg.occ_wd, sg.fifo_wrreq, sg.fifo_rdreq, sg.fifo_sclr}, 0);
    check("rst_addr_data", {sg.occ_addr, sg.fifo_data}, 0);
    check("rst_status", {sg.game_over, sg.win, sg.score, sg.length}, 0);
    reset = 1'b1;
    step();

    // Start: 256 clears then three seed pushes.
    start_game();
    check("clear_sclr", sg.fifo_sclr, 1);
    wait_lock_low(400, n);
    check("start_lock_cycles", n + 1, 260);
    check("clear_writes", clr_writes, 256);
    check("seed_set_writes", set_writes, 3);
    check("seed_pushes", {push_log.size() == 3 ? {push_log[0], push_log[1], push_log[2]} : 24'h0}, 24'h546474);
    check("seed_length", sg.length, 3);

    // Normal move into empty cell.
    p0 = push_log.size(); q0 = pop_log.size();
    pulse_tick(8'h84);
    wait_lock_low(20, n);
    check("move_latency", n, 4);
    check("move_pop", (pop_log.size() == q0 + 1) ? pop_log[q0] : 8'hxx, 8'h54);
    check("move_push", (push_log.size() == p0 + 1) ? push_log[p0] : 8'hxx, 8'h84);
    check("move_occ", {occ_mem[8'h54], occ_mem[8'h84]}, 2'b01);
    check("move_length", sg.length, 3);

    // Grow: no pop, food request, ack after 5 cycles.
    sg.food_pos = 8'h94;
    p0 = push_log.size(); q0 = pop_log.size(); f0 = food_reqs;
    pulse_tick(8'h94);
    n = 0;
    while (sg.food_req !== 1'b1 && n < 20) begin step(); n++; end
    check("food_req_latency", n, 3);
    lowcnt = 0;
    repeat (5) begin step(); if (sg.lock !== 1'b1) lowcnt++; end
    check("food_lock_held", lowcnt, 0);
    sg.food_ack = 1'b1;
    step();
    sg.food_ack = 1'b0;
    sg.food_pos = 8'h00;
    check("food_lock_release", sg.lock, 0);
    check("food_req_pulses", food_reqs - f0, 1);
    check("food_no_pop", pop_log.size() - q0, 0);
    check("food_push", (push_log.size() == p0 + 1) ? push_log[p0] : 8'hxx, 8'h94);
    check("food_score_len", {sg.score, sg.length}, {8'd1, 8'd4});

    // Tail chase: head moves onto the vacating tail cell.
    p0 = push_log.size(); q0 = pop_log.size();
    pulse_tick(8'h64);
    wait_lock_low(20, n);
    check("chase_latency", n, 4);
    check("chase_pop_push", {(pop_log.size() == q0 + 1) ? pop_log[q0] : 8'hxx,
                             (push_log.size() == p0 + 1) ? push_log[p0] : 8'hxx}, 16'h6464);
    check("chase_no_over", {sg.game_over, sg.length}, {1'b0, 8'd4});
    check("chase_occ", occ_mem[8'h64], 1);

    // Second meal reaches MAX_LEN=5: win, no food request.
    sg.food_pos = 8'ha4;
    f0 = food_reqs;
    pulse_tick(8'ha4);
    n = 0;
    while (sg.win !== 1'b1 && n < 20) begin step(); n++; end
    check("win_latency", n, 3);
    step();
    check("win_status", {sg.win, sg.game_over, sg.lock, sg.score, sg.length}, {3'b101, 8'd2, 8'd5});
    check("win_no_food_req", food_reqs - f0, 0);
    sg.food_pos = 8'h00;

    // Restart, then collide with a body segment that is not the tail.
    start_game();
    check("restart_clear", {sg.fifo_sclr, sg.win, sg.score, sg.length}, {2'b10, 16'h0});
    wait_lock_low(300, n);
    check("restart_length", sg.length, 3);
    p0 = push_log.size(); q0 = pop_log.size();
    pulse_tick(8'h64);
    n = 0;
    while (sg.game_over !== 1'b1 && n < 20) begin step(); n++; end
    check("hit_latency", n, 2);
    check("hit_lock", sg.lock, 1);
    pulse_tick(8'h84);
    repeat (6) step();
    check("hit_no_fifo", {push_log.size() - p0, pop_log.size() - q0}, 0);
    check("hit_hold", {sg.game_over, sg.lock, sg.length}, {2'b11, 8'd3});
    start_game();
    check("hit_restart", {sg.game_over, sg.score, sg.fifo_sclr}, {1'b0, 8'd0, 1'b1});
    wait_lock_low(300, n);
    check("hit_restart_lock", sg.lock, 0);

    // Reset asserted while in POP.
    pulse_tick(8'h84);
    step();
    step();
    check("pop_strobe", sg.fifo_rdreq, 1);
    reset = 1'b0;
    #1;
    check("midrst_strobes", {sg.fifo_rdreq, sg.fifo_wrreq, sg.occ_we, sg.food_req}, 0);
    check("midrst_status", {sg.lock, sg.occ_addr, sg.length, sg.score}, {1'b1, 24'h0});
    step();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
